// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl
// ------------
// Run-control unit between the board clock and the CPU core. It divides the
// board clock into a CPU clock with a runtime-selectable ratio, freezes that
// clock at low level when the CPU asks to halt, and resumes or single-steps it
// from debounced push-buttons. It also counts CPU clock rising edges for
// LED/debug display.
//
// Optional feature macro: RUN_CTRL_STEP_EN
//   defined   : btn_step is synchronized and debounced, and a step press in
//               HALTED runs exactly one CPU clock period.
//   undefined : btn_step is ignored, no step debouncer is built and HALTED
//               is left only through a run press.
//
// Ports
//   clk        in   board clock, the only clock
//   rst        in   asynchronous active-high reset
//   div_ratio  in   CPU clock phase length minus one, sampled every cycle
//   halt_req   in   CPU halt request (clk domain), acted on at its rising edge
//   btn_run    in   raw asynchronous resume button
//   btn_step   in   raw asynchronous single-step button
//   cpu_clk    out  registered divided CPU clock
//   cpu_rise   out  one-clk pulse in the cycle cpu_clk goes 0->1
//   halted     out  high while in the HALTED state
//   cpu_cycles out  number of cpu_clk rising edges, wraps to 0

module cpu_run_ctrl #(
  parameter int unsigned DIV_WIDTH       = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned CYC_WIDTH       = 32,
  parameter bit          START_HALTED    = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] div_ratio,
  input  logic                 halt_req,
  input  logic                 btn_run,
  input  logic                 btn_step,
  output logic                 cpu_clk,
  output logic                 cpu_rise,
  output logic                 halted,
  output logic [CYC_WIDTH-1:0] cpu_cycles
);

  // Stability counter wide enough to hold DEBOUNCE_CYCLES-1 (at least 1 bit).
  localparam int unsigned     DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_STEP   = 2'd2
  } state_t;

  localparam state_t RST_STATE = START_HALTED ? ST_HALTED : ST_RUN;

  state_t                 state_q;
  logic [DIV_WIDTH-1:0]   cnt_q;
  logic                   halt_req_q;
  logic                   halt_pend_q;
  logic                   cpu_clk_q;
  logic                   cpu_rise_q;
  logic                   halted_q;
  logic [CYC_WIDTH-1:0]   cycles_q;

  logic                   tick_s;
  logic                   halt_edge_s;
  logic                   halt_want_s;
  logic                   run_press_s;
  logic                   step_press_s;

  // ---------------------------------------------------------------------------
  // Run button: 2-flop synchronizer followed by a stability counter. The
  // counter only advances while the synchronized sample differs from the
  // accepted level, so any sample equal to the level restarts the count.
  // ---------------------------------------------------------------------------
  logic            run_s1_q;
  logic            run_s2_q;
  logic            run_lvl_q;
  logic            run_lvl_d;
  logic [DB_W-1:0] run_cnt_q;
  logic [DB_W-1:0] run_cnt_d;

  // Next debounced run level and its press event
  always_comb begin
    run_cnt_d = run_cnt_q;
    run_lvl_d = run_lvl_q;
    if (run_s2_q == run_lvl_q) begin
      run_cnt_d = {DB_W{1'b0}};
    end else if (run_cnt_q == DB_LAST) begin
      run_lvl_d = run_s2_q;
      run_cnt_d = {DB_W{1'b0}};
    end else begin
      run_cnt_d = run_cnt_q + DB_W'(1);
    end
    run_press_s = run_lvl_d & ~run_lvl_q;
  end

  // Run button synchronizer and debounce state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_s1_q  <= 1'b0;
      run_s2_q  <= 1'b0;
      run_lvl_q <= 1'b0;
      run_cnt_q <= {DB_W{1'b0}};
    end else begin
      run_s1_q  <= btn_run;
      run_s2_q  <= run_s1_q;
      run_lvl_q <= run_lvl_d;
      run_cnt_q <= run_cnt_d;
    end
  end

`ifdef RUN_CTRL_STEP_EN
  // Step button: same structure as the run button.
  logic            step_s1_q;
  logic            step_s2_q;
  logic            step_lvl_q;
  logic            step_lvl_d;
  logic [DB_W-1:0] step_cnt_q;
  logic [DB_W-1:0] step_cnt_d;

  // Next debounced step level and its press event
  always_comb begin
    step_cnt_d = step_cnt_q;
    step_lvl_d = step_lvl_q;
    if (step_s2_q == step_lvl_q) begin
      step_cnt_d = {DB_W{1'b0}};
    end else if (step_cnt_q == DB_LAST) begin
      step_lvl_d = step_s2_q;
      step_cnt_d = {DB_W{1'b0}};
    end else begin
      step_cnt_d = step_cnt_q + DB_W'(1);
    end
    step_press_s = step_lvl_d & ~step_lvl_q;
  end

  // Step button synchronizer and debounce state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_s1_q  <= 1'b0;
      step_s2_q  <= 1'b0;
      step_lvl_q <= 1'b0;
      step_cnt_q <= {DB_W{1'b0}};
    end else begin
      step_s1_q  <= btn_step;
      step_s2_q  <= step_s1_q;
      step_lvl_q <= step_lvl_d;
      step_cnt_q <= step_cnt_d;
    end
  end
`else
  // Without the step feature the button is not used at all.
  logic unused_btn_step_s;
  assign unused_btn_step_s = btn_step;
  assign step_press_s      = 1'b0;
`endif

  // Phase tick and halt request decode. The halt edge is folded in directly
  // so a request that lands on a tick cycle is not delayed by a whole phase.
  always_comb begin
    tick_s      = (cnt_q >= div_ratio);
    halt_edge_s = halt_req & ~halt_req_q;
    halt_want_s = halt_pend_q | halt_edge_s;
  end

  // Run-control state machine with phase counter, halt latch and outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RST_STATE;
      cnt_q       <= {DIV_WIDTH{1'b0}};
      halt_req_q  <= 1'b0;
      halt_pend_q <= 1'b0;
      cpu_clk_q   <= 1'b0;
      cpu_rise_q  <= 1'b0;
      halted_q    <= START_HALTED;
      cycles_q    <= {CYC_WIDTH{1'b0}};
    end else begin
      halt_req_q <= halt_req;
      cpu_rise_q <= 1'b0;
      cnt_q      <= tick_s ? {DIV_WIDTH{1'b0}} : cnt_q + DIV_WIDTH'(1);
      case (state_q)
        ST_RUN: begin
          halt_pend_q <= halt_want_s;
          if (tick_s) begin
            if (cpu_clk_q) begin
              // A pending halt still lets the clock fall first.
              cpu_clk_q <= 1'b0;
            end else if (halt_want_s) begin
              state_q     <= ST_HALTED;
              halted_q    <= 1'b1;
              halt_pend_q <= 1'b0;
            end else begin
              cpu_clk_q  <= 1'b1;
              cpu_rise_q <= 1'b1;
              cycles_q   <= cycles_q + CYC_WIDTH'(1);
            end
          end
        end
        ST_HALTED: begin
          // Halt edges seen while frozen are dropped.
          halt_pend_q <= 1'b0;
          cpu_clk_q   <= 1'b0;
          if (run_press_s) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
            cnt_q    <= {DIV_WIDTH{1'b0}};
          end else if (step_press_s) begin
            state_q  <= ST_STEP;
            halted_q <= 1'b0;
            cnt_q    <= {DIV_WIDTH{1'b0}};
          end
        end
        ST_STEP: begin
          halt_pend_q <= 1'b0;
          if (tick_s) begin
            if (!cpu_clk_q) begin
              cpu_clk_q  <= 1'b1;
              cpu_rise_q <= 1'b1;
              cycles_q   <= cycles_q + CYC_WIDTH'(1);
            end else begin
              cpu_clk_q <= 1'b0;
              state_q   <= ST_HALTED;
              halted_q  <= 1'b1;
            end
          end
        end
        default: begin
          // Unreachable encoding: freeze the CPU clock safely.
          state_q     <= ST_HALTED;
          halted_q    <= 1'b1;
          cpu_clk_q   <= 1'b0;
          halt_pend_q <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_clk    = cpu_clk_q;
  assign cpu_rise   = cpu_rise_q;
  assign halted     = halted_q;
  assign cpu_cycles = cycles_q;

endmodule
